// File: rtl/wubsuit_uart_pkg.sv
// Shared types and constants for the WubSuit multi-channel UART receiver hub.
package wubsuit_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Bit periods for the 10 MHz SYSCLK
  localparam int unsigned MIDI_CPB = 320;
  localparam int unsigned XBEE_CPB = 1042;

  // Channel-index width; never narrower than one bit
  function automatic int unsigned chw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wubsuit_uart_rx_chan.sv
// One 8N1 receive channel: 2-FF synchronizer, framing FSM and byte FIFO.
module wubsuit_uart_rx_chan
  import wubsuit_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = MIDI_CPB,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       pop,
  output logic       empty,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          sync1, line;
  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    nbit, nbit_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, ferr_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= rxd;
      line  <= sync1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    nbit_n  = nbit;
    shreg_n = shreg;
    push    = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!line) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          state_n = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shreg_n = {line, shreg[7:1]};
          nbit_n  = nbit + 1'b1;
          if (nbit == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (line) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (line) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A push into a full FIFO still lands when the same cycle pops a slot
  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);
  assign data  = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nbit      <= '0;
      shreg     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      nbit      <= nbit_n;
      shreg     <= shreg_n;
      frame_err <= ferr_n;
      overrun   <= push && full && !pop;
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      count <= count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= shreg;
  end

endmodule

// File: rtl/wubsuit_uart_rx_hub.sv
// NCH-channel UART receiver hub: per-channel receivers merged by a
// round-robin arbiter into one valid/ready byte stream tagged with its channel.
module wubsuit_uart_rx_hub
  import wubsuit_uart_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned CLKS_PER_BIT = MIDI_CPB,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  SYSCLK,
  input  logic                  SYSRESET,
  input  logic [NCH-1:0]        RXD,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [7:0]            OUT_DATA,
  output logic [chw(NCH)-1:0]   OUT_CH,
  output logic [NCH-1:0]        FRAME_ERR,
  output logic [NCH-1:0]        OVERRUN
);

  localparam int unsigned CW = chw(NCH);

  logic [NCH-1:0] empty, pop, avail;
  logic [7:0]     rdata [NCH];
  logic [CW-1:0]  last, grant;
  logic           found, load;
  int unsigned    idx;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    wubsuit_uart_rx_chan #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_chan (
      .clk      (SYSCLK),
      .rst      (SYSRESET),
      .rxd      (RXD[g]),
      .pop      (pop[g]),
      .empty    (empty[g]),
      .data     (rdata[g]),
      .frame_err(FRAME_ERR[g]),
      .overrun  (OVERRUN[g])
    );
  end

  // Search begins one past the last grant and wraps, so the last grant is tried last
  always_comb begin
    grant = last;
    found = 1'b0;
    idx   = 0;
    avail = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx   = (32'(last) + i) % NCH;
      avail = ~empty >> idx;
      if (!found && avail[0]) begin
        grant = CW'(idx);
        found = 1'b1;
      end
    end
  end

  assign load = (!OUT_VALID || OUT_READY) && found;
  assign pop  = load ? (NCH'(1) << grant) : '0;

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_CH    <= '0;
      last      <= CW'(NCH - 1);
    end else if (load) begin
      OUT_VALID <= 1'b1;
      OUT_DATA  <= rdata[grant];
      OUT_CH    <= grant;
      last      <= grant;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wubsuit_uart_rx_hub.sv
// Self-checking bench for wubsuit_uart_rx_hub: vector table, directed corner
// sequences and randomized traffic against per-channel expected-byte queues.
`timescale 1ns/1ps
module tb_wubsuit_uart_rx_hub;
  import wubsuit_uart_pkg::*;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CPB   = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned H     = CPB / 2;
  // pin falling edge (just after a posedge) to OUT_VALID visible, in posedges
  localparam int          LAT   = H + 9 * CPB + 4;

  logic                 SYSCLK;
  logic                 SYSRESET;
  logic [NCH-1:0]       RXD;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic [7:0]           OUT_DATA;
  logic [chw(NCH)-1:0]  OUT_CH;
  logic [NCH-1:0]       FRAME_ERR;
  logic [NCH-1:0]       OVERRUN;

  wubsuit_uart_rx_hub #(
    .NCH         (NCH),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .SYSCLK   (SYSCLK),
    .SYSRESET (SYSRESET),
    .RXD      (RXD),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_DATA (OUT_DATA),
    .OUT_CH   (OUT_CH),
    .FRAME_ERR(FRAME_ERR),
    .OVERRUN  (OVERRUN)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  byte unsigned expq [NCH][$];
  int ferr_cnt [NCH];
  int ovr_cnt [NCH];

  typedef struct {
    int          ch;
    byte unsigned data;
    int unsigned cyc;
  } rx_t;
  rx_t log_q[$];

  typedef struct {
    int           kind;   // 0 frame, 1 glitch
    int           ch;
    byte unsigned data;
    bit           stop;
    int           hold;   // low time after a bad stop bit, or glitch length
    int           exp_lat;
    int           exp_ferr;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask

  task automatic send_frame(input int ch, input byte unsigned d, input bit stop,
                            input int hold_low, input int gap);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD[ch] = bits[i];
      wait_cycles(CPB);
    end
    if (hold_low > 0) wait_cycles(hold_low);
    RXD[ch] = 1'b1;
    if (gap > 0) wait_cycles(gap);
  endtask

  task automatic glitch(input int ch, input int len);
    RXD[ch] = 1'b0;
    wait_cycles(len);
    RXD[ch] = 1'b1;
    wait_cycles(CPB);
  endtask

  always @(posedge SYSCLK) cyc <= cyc + 1;

  // Scoreboard: every accepted byte must be the oldest expected byte of its channel
  always @(negedge SYSCLK) begin : monitor
    rx_t r;
    if (!SYSRESET) begin
      for (int c = 0; c < NCH; c++) begin
        if (FRAME_ERR[c]) ferr_cnt[c]++;
        if (OVERRUN[c]) ovr_cnt[c]++;
      end
      if (OUT_VALID && OUT_READY) begin
        r.ch = int'(OUT_CH);
        r.data = OUT_DATA;
        r.cyc = cyc;
        log_q.push_back(r);
        chk($sformatf("byte_expected_ch%0d", OUT_CH), int'(expq[OUT_CH].size() > 0), 1);
        if (expq[OUT_CH].size() > 0)
          chk($sformatf("data_ch%0d", OUT_CH), int'(OUT_DATA), int'(expq[OUT_CH].pop_front()));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  bit rnd_on;
  int f0, lat, n0, b0;
  int ferr_base [NCH];
  int ovr_base [NCH];
  int ferr_exp [NCH];
  byte unsigned ob [6];

  initial begin
    RXD = '1;
    OUT_READY = 1'b1;
    SYSRESET = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      ferr_cnt[c] = 0;
      ovr_cnt[c] = 0;
    end
    vt = '{
      '{0, 2, 8'hA5, 1'b1, 0,       LAT, 0},
      '{1, 0, 8'h00, 1'b1, H - 3,   0,   0},
      '{0, 0, 8'h3C, 1'b1, 0,       LAT, 0},
      '{0, 1, 8'h5A, 1'b0, 10 * CPB, 0,  1},
      '{0, 1, 8'hC3, 1'b1, 0,       LAT, 0},
      '{0, 3, 8'h00, 1'b1, 0,       LAT, 0},
      '{0, 0, 8'hFF, 1'b1, 0,       LAT, 0},
      '{0, 2, 8'h80, 1'b0, 0,       0,   1},
      '{0, 2, 8'h01, 1'b1, 0,       LAT, 0}
    };

    wait_cycles(3);
    chk("rst_valid", int'(OUT_VALID), 0);
    chk("rst_data", int'(OUT_DATA), 0);
    chk("rst_ch", int'(OUT_CH), 0);
    chk("rst_ferr", int'(FRAME_ERR), 0);
    chk("rst_ovr", int'(OVERRUN), 0);
    SYSRESET = 1'b0;
    wait_cycles(4);

    // Vector table: latency to OUT_VALID and framing-error pulses per entry
    for (int k = 0; k < 9; k++) begin
      f0 = ferr_cnt[vt[k].ch];
      if (vt[k].kind == 0 && vt[k].stop) expq[vt[k].ch].push_back(vt[k].data);
      fork
        if (vt[k].kind == 0) send_frame(vt[k].ch, vt[k].data, vt[k].stop, vt[k].hold, CPB);
        else glitch(vt[k].ch, vt[k].hold);
      join_none
      lat = 0;
      for (int n = 1; n <= 11 * CPB; n++) begin
        @(posedge SYSCLK);
        #1;
        if (OUT_VALID && lat == 0) lat = n;
      end
      wait fork;
      chk($sformatf("vec%0d_latency", k), lat, vt[k].exp_lat);
      chk($sformatf("vec%0d_frame_err", k), ferr_cnt[vt[k].ch] - f0, vt[k].exp_ferr);
    end
    for (int c = 0; c < NCH; c++) chk($sformatf("vec_queue_empty_ch%0d", c), expq[c].size(), 0);

    // Overrun: stalled output, four queued, sixth byte dropped
    OUT_READY = 1'b0;
    b0 = ovr_cnt[3];
    for (int j = 0; j < 6; j++) begin
      ob[j] = byte'($urandom_range(1, 255));
      if (j < 5) expq[3].push_back(ob[j]);
      send_frame(3, ob[j], 1'b1, 0, 2);
      if (j == 1) chk("stall_data_early", int'(OUT_DATA), int'(ob[0]));
      if (j == 4) chk("ovr_after_5", ovr_cnt[3] - b0, 0);
    end
    wait_cycles(4);
    chk("ovr_after_6", ovr_cnt[3] - b0, 1);
    chk("stall_valid", int'(OUT_VALID), 1);
    chk("stall_data", int'(OUT_DATA), int'(ob[0]));
    chk("stall_ch", int'(OUT_CH), 3);
    OUT_READY = 1'b1;
    wait_cycles(20);
    chk("ovr_drained", expq[3].size(), 0);

    // Simultaneous bursts: round-robin from ch0 on consecutive cycles
    for (int rep = 0; rep < 2; rep++) begin
      log_q.delete();
      for (int c = 0; c < NCH; c++) begin
        automatic int cc = c;
        automatic byte unsigned dd = byte'(17 * (cc + 1) + 64 * rep);
        expq[cc].push_back(dd);
        fork
          send_frame(cc, dd, 1'b1, 0, 4);
        join_none
      end
      wait fork;
      wait_cycles(8);
      chk($sformatf("burst%0d_count", rep), log_q.size(), NCH);
      if (log_q.size() == NCH) begin
        for (int i = 0; i < NCH; i++) begin
          chk($sformatf("burst%0d_order%0d", rep, i), log_q[i].ch, i);
          chk($sformatf("burst%0d_cycle%0d", rep, i), int'(log_q[i].cyc - log_q[0].cyc), i);
        end
      end
    end

    // Reset mid-DATA with a stalled byte in the output register
    OUT_READY = 1'b0;
    send_frame(2, 8'h96, 1'b1, 0, 4);
    chk("prerst_valid", int'(OUT_VALID), 1);
    fork
      send_frame(0, 8'hF0, 1'b1, 0, CPB);
    join_none
    wait_cycles(6 * CPB + 5);
    SYSRESET = 1'b1;
    wait_cycles(1);
    chk("midrst_valid", int'(OUT_VALID), 0);
    chk("midrst_data", int'(OUT_DATA), 0);
    chk("midrst_ch", int'(OUT_CH), 0);
    chk("midrst_ferr", int'(FRAME_ERR), 0);
    chk("midrst_ovr", int'(OVERRUN), 0);
    SYSRESET = 1'b0;
    OUT_READY = 1'b1;
    n0 = log_q.size();
    wait fork;
    wait_cycles(6 * CPB);
    chk("midrst_no_byte", log_q.size() - n0, 0);
    expq[0].push_back(8'h6B);
    send_frame(0, 8'h6B, 1'b1, 0, 8);
    chk("postrst_byte", log_q.size() - n0, 1);

    // Randomized concurrent traffic with random back-pressure
    for (int c = 0; c < NCH; c++) begin
      ferr_base[c] = ferr_cnt[c];
      ovr_base[c] = ovr_cnt[c];
      ferr_exp[c] = 0;
    end
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        OUT_READY = 1'($urandom_range(0, 1));
        wait_cycles(1);
      end
    join_none
    for (int c = 0; c < NCH; c++) begin
      automatic int cc = c;
      fork
        for (int f = 0; f < 5; f++) begin
          automatic byte unsigned dd = byte'($urandom);
          automatic bit good = ($urandom_range(0, 4) != 0);
          if (good) expq[cc].push_back(dd);
          else ferr_exp[cc]++;
          send_frame(cc, dd, good, good ? 0 : int'($urandom_range(0, 2 * CPB)),
                     int'($urandom_range(1, CPB)));
        end
      join_none
    end
    for (int t = 0; t < 60 * CPB; t++) begin
      wait_cycles(1);
      if (ferr_exp[0] + expq[0].size() >= 0 && t > 6 * CPB * 5 + 4 * CPB) break;
    end
    rnd_on = 1'b0;
    wait fork;
    OUT_READY = 1'b1;
    wait_cycles(30);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("rnd_queue_empty_ch%0d", c), expq[c].size(), 0);
      chk($sformatf("rnd_frame_err_ch%0d", c), ferr_cnt[c] - ferr_base[c], ferr_exp[c]);
      chk($sformatf("rnd_overrun_ch%0d", c), ovr_cnt[c] - ovr_base[c], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
